// File: rtl/irrigation_zone_scheduler_if.sv
// Pump/valve scheduler bundle: zone requests and sensors in,
// valve/pump drives and status out.
interface irrigation_zone_scheduler_if #(
    parameter int NZ = 4,
    parameter int ZW = 2
);
    logic          tick;
    logic          enable;
    logic [NZ-1:0] req;
    logic          tank_low;
    logic [NZ-1:0] valve;
    logic          pump;
    logic          busy;
    logic [ZW-1:0] zone_id;
    logic          fault;

    modport master (
        output tick, enable, req, tank_low,
        input  valve, pump, busy, zone_id, fault
    );

    modport slave (
        input  tick, enable, req, tank_low,
        output valve, pump, busy, zone_id, fault
    );
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin single-pump irrigation scheduler with prime,
// bounded watering, dead time and low-tank shutdown.
module irrigation_zone_scheduler #(
    parameter int NZ     = 4,
    parameter int MAX_ON = 60,
    parameter int GAP    = 3,
    parameter int ZW     = 2
) (
    input logic clk,
    input logic reset,
    irrigation_zone_scheduler_if.slave bus
);
    localparam int CMAX = (MAX_ON > GAP) ? MAX_ON : GAP;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_WATER,
        S_GAP,
        S_FAULT
    } state_t;

    state_t        r_state;
    logic [NZ-1:0] r_valve;
    logic          r_pump;
    logic          r_busy;
    logic [ZW-1:0] r_zone;
    logic          r_fault;
    logic [CW-1:0] r_cnt;
    logic [ZW-1:0] r_ptr;

    logic [NZ-1:0] w_rot;
    logic          w_found;
    int            w_off;
    logic [ZW-1:0] w_next;
    logic          w_zone_req;
    logic          w_timeout;
    logic          w_stop;

    function automatic logic [NZ-1:0] onehot(input logic [ZW-1:0] z);
        return NZ'(1) << z;
    endfunction

    // Rotate so bit 0 is the zone just after the last grant.
    assign w_rot = NZ'({bus.req, bus.req} >> (int'(r_ptr) + 1));

    always_comb begin
        w_found = 1'b0;
        w_off   = 0;
        for (int k = NZ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = k;
            end
        end
        w_next = ZW'((int'(r_ptr) + 1 + w_off) % NZ);
    end

    assign w_zone_req = |(bus.req & onehot(r_zone));
    assign w_timeout  = bus.tick && (r_cnt == CW'(MAX_ON - 1));
    assign w_stop     = !bus.enable ||
                        ((r_state == S_WATER) &&
                         (w_timeout || !w_zone_req));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valve <= '0;
            r_pump  <= 1'b0;
            r_busy  <= 1'b0;
            r_zone  <= '0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_ptr   <= ZW'(NZ - 1);
        end else if (bus.tank_low) begin
            r_state <= S_FAULT;
            r_valve <= '0;
            r_pump  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.enable && w_found) begin
                        r_state <= S_PRIME;
                        r_ptr   <= w_next;
                        r_zone  <= w_next;
                        r_valve <= onehot(w_next);
                        r_busy  <= 1'b1;
                    end
                end
                S_PRIME, S_WATER: begin
                    if (w_stop) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                        r_valve <= '0;
                        r_pump  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (bus.tick) begin
                        if (r_state == S_PRIME) begin
                            r_state <= S_WATER;
                            r_cnt   <= '0;
                            r_pump  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (bus.tick) begin
                        if (r_cnt == CW'(GAP - 1)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_FAULT: begin
                    r_state <= S_GAP;
                    r_cnt   <= '0;
                    r_fault <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.valve   = r_valve;
    assign bus.pump    = r_pump;
    assign bus.busy    = r_busy;
    assign bus.zone_id = r_zone;
    assign bus.fault   = r_fault;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench for irrigation_zone_scheduler (NZ=4, MAX_ON=5,
// GAP=2) with an expected-output queue checked after each edge.
module tb_irrigation_zone_scheduler;
    localparam int NZ = 4;
    localparam int ZW = 2;

    typedef struct {
        string         tag;
        logic [NZ-1:0] v;
        logic          p;
        logic          b;
        logic [ZW-1:0] z;
        logic          f;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;

    irrigation_zone_scheduler_if #(.NZ(NZ), .ZW(ZW)) bus ();

    irrigation_zone_scheduler #(
        .NZ(NZ), .MAX_ON(5), .GAP(2), .ZW(ZW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [NZ-1:0] v,
                              input logic p, input logic b,
                              input logic [ZW-1:0] z, input logic f);
        exp_t e;
        e.tag = tag; e.v = v; e.p = p; e.b = b; e.z = z; e.f = f;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (bus.valve === e.v) else begin
                n_fail++;
                $error("FAIL %s valve got %b want %b", e.tag, bus.valve, e.v);
            end
            n_assert++;
            assert (bus.pump === e.p) else begin
                n_fail++;
                $error("FAIL %s pump got %b want %b", e.tag, bus.pump, e.p);
            end
            n_assert++;
            assert (bus.busy === e.b) else begin
                n_fail++;
                $error("FAIL %s busy got %b want %b", e.tag, bus.busy, e.b);
            end
            n_assert++;
            assert (bus.zone_id === e.z) else begin
                n_fail++;
                $error("FAIL %s zone_id got %0d want %0d", e.tag, bus.zone_id, e.z);
            end
            n_assert++;
            assert (bus.fault === e.f) else begin
                n_fail++;
                $error("FAIL %s fault got %b want %b", e.tag, bus.fault, e.f);
            end
        end
    endtask

    task automatic step(input bit tk);
        bus.tick = tk;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    // One edge with the given tick; outputs checked just after it.
    task automatic go(input bit tk, input string tag,
                      input logic [NZ-1:0] v, input logic p,
                      input logic b, input logic [ZW-1:0] z,
                      input logic f);
        expect_out(tag, v, p, b, z, f);
        step(tk);
        check();
    endtask

    // Quiet cycle then a tick cycle, outputs unchanged across both.
    task automatic tk2(input string tag, input logic [NZ-1:0] v,
                       input logic p, input logic b,
                       input logic [ZW-1:0] z, input logic f);
        go(1'b0, tag, v, p, b, z, f);
        go(1'b1, tag, v, p, b, z, f);
    endtask

    // Two-tick dead time ending in IDLE, then the next grant.
    task automatic gap_then_grant(input string tag, input logic [ZW-1:0] zold,
                                  input logic [NZ-1:0] vnew,
                                  input logic [ZW-1:0] znew);
        tk2({tag, "_gap1"}, '0, 1'b0, 1'b0, zold, 1'b0);
        go(1'b0, {tag, "_gap_hold"}, '0, 1'b0, 1'b0, zold, 1'b0);
        go(1'b1, {tag, "_gap2"}, '0, 1'b0, 1'b0, zold, 1'b0);
        go(1'b0, {tag, "_grant"}, vnew, 1'b0, 1'b1, znew, 1'b0);
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.enable = 1'b0;
        bus.req = '0;
        bus.tank_low = 1'b0;

        @(posedge clk);
        #1;
        expect_out("reset", '0, 1'b0, 1'b0, 2'd0, 1'b0);
        check();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single zone, timeout, re-grant
        bus.enable = 1'b1;
        bus.req = 4'b0100;
        go(1'b0, "sz_grant", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        go(1'b0, "sz_prime", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
        go(1'b1, "sz_pump_on", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++)
            tk2("sz_water", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
        go(1'b0, "sz_water_last", 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
        go(1'b1, "sz_timeout", '0, 1'b0, 1'b0, 2'd2, 1'b0);
        gap_then_grant("sz", 2'd2, 4'b0100, 2'd2);

        // enable drop while priming aborts
        bus.enable = 1'b0;
        go(1'b0, "prime_abort", '0, 1'b0, 1'b0, 2'd2, 1'b0);
        bus.req = 4'b1111;
        tk2("abort_gap1", '0, 1'b0, 1'b0, 2'd2, 1'b0);
        tk2("abort_gap2", '0, 1'b0, 1'b0, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++)
            tk2("en_off", '0, 1'b0, 1'b0, 2'd2, 1'b0);

        // asynchronous reset mid-WATER
        bus.enable = 1'b1;
        go(1'b0, "ar_grant", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
        go(1'b1, "ar_water", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
        go(1'b0, "ar_water2", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_out("ar_async", '0, 1'b0, 1'b0, 2'd0, 1'b0);
        check();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // round-robin 0,1,3,0 with drops two ticks into WATER
        bus.req = 4'b1011;
        go(1'b0, "rr_grant0", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
        go(1'b0, "rr0_prime", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
        go(1'b1, "rr0_water", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        tk2("rr0_t", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        tk2("rr0_t", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        bus.req = 4'b1010;
        go(1'b0, "rr0_drop", '0, 1'b0, 1'b0, 2'd0, 1'b0);
        bus.req = 4'b1011;
        gap_then_grant("rr1", 2'd0, 4'b0010, 2'd1);

        go(1'b0, "rr1_prime", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
        go(1'b1, "rr1_water", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        tk2("rr1_t", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        tk2("rr1_t", 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        bus.req = 4'b1001;
        go(1'b0, "early_drop", '0, 1'b0, 1'b0, 2'd1, 1'b0);
        bus.req = 4'b1011;
        gap_then_grant("rr3", 2'd1, 4'b1000, 2'd3);

        go(1'b0, "rr3_prime", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
        go(1'b1, "rr3_water", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
        tk2("rr3_t", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
        tk2("rr3_t", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
        bus.req = 4'b0011;
        go(1'b0, "rr3_drop", '0, 1'b0, 1'b0, 2'd3, 1'b0);
        bus.req = 4'b1011;
        gap_then_grant("rr0b", 2'd3, 4'b0001, 2'd0);

        go(1'b0, "rr0b_prime", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
        go(1'b1, "rr0b_water", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        tk2("rr0b_t", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        bus.req = 4'b1000;
        go(1'b0, "rr0b_drop", '0, 1'b0, 1'b0, 2'd0, 1'b0);
        gap_then_grant("tk3", 2'd0, 4'b1000, 2'd3);

        // low tank while watering zone 3
        go(1'b0, "tk_prime", 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
        go(1'b1, "tk_water", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
        tk2("tk_t", 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
        bus.tank_low = 1'b1;
        go(1'b0, "tank_fault", '0, 1'b0, 1'b0, 2'd3, 1'b1);
        go(1'b1, "tank_hold", '0, 1'b0, 1'b0, 2'd3, 1'b1);
        bus.tank_low = 1'b0;
        bus.req = 4'b1011;
        go(1'b0, "tank_release", '0, 1'b0, 1'b0, 2'd3, 1'b0);
        gap_then_grant("tk_resume", 2'd3, 4'b0001, 2'd0);

        // tick at counter 4, req drop and tank_low in one cycle
        go(1'b0, "sim_prime", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
        go(1'b1, "sim_water", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            tk2("sim_t", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        go(1'b0, "sim_pre", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        bus.req = 4'b1010;
        bus.tank_low = 1'b1;
        go(1'b1, "simul_fault", '0, 1'b0, 1'b0, 2'd0, 1'b1);
        bus.tank_low = 1'b0;
        go(1'b0, "sim_release", '0, 1'b0, 1'b0, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/irrigation_zone_scheduler.md
# irrigation_zone_scheduler

Shares the single irrigation pump among NZ watering zones. Each zone raises a dry-soil request. The scheduler grants zones one at a time in round-robin order. For each granted zone it opens the valve, starts the pump one tick later, bounds the watering time, and enforces a dead time between zones. It sits between the per-zone moisture comparators and the valve/pump drivers, and shuts everything down when the tank runs low.

## Interface
- NZ, 4: number of zones (2..8).
- MAX_ON, 60: maximum watering time per grant, in ticks (≥2).
- GAP, 3: all-off dead time between grants, in ticks (≥1).
- ZW, 2: width of zone_id; must satisfy 2^ZW ≥ NZ.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- tick  in  1  one-cycle time-base strobe (e.g. 1 Hz); all durations count ticks.
- enable  in  1  global irrigation enable (level).
- req  in  NZ  per-zone watering request; bit i high = zone i dry.
- tank_low  in  1  reservoir low-level sensor (level).
- valve  out  NZ  valve drives; one-hot or zero.
- pump  out  1  pump drive.
- busy  out  1  high in PRIME or WATER.
- zone_id  out  ZW  index of the granted zone; holds its last value when idle.
- fault  out  1  high while in FAULT.

## Operation
- States: IDLE, PRIME, WATER, GAP, FAULT. All outputs are registered.
- Reset values: state = IDLE, valve = 0, pump = 0, busy = 0, zone_id = 0, fault = 0, tick counter = 0. The round-robin pointer resets to NZ-1, so zone 0 has first priority.
- IDLE:
  - If enable=1, tank_low=0 and req≠0, grant the first requesting zone found by searching upward from pointer+1, modulo NZ.
  - On a grant, update pointer and zone_id to the granted zone and go to PRIME.
  - If tank_low=1, go to FAULT.
- PRIME:
  - valve[zone_id]=1, pump=0.
  - Stay until the next tick, then go to WATER with the counter cleared.
- WATER:
  - valve[zone_id]=1, pump=1.
  - The counter increments on each tick.
  - Go to GAP when any of these holds: req[zone_id]=0 (sampled every cycle); a tick arrives with counter = MAX_ON-1; enable=0.
- GAP:
  - All outputs 0; counter cleared on entry.
  - Return to IDLE after GAP ticks.
  - tank_low=1 goes to FAULT.
- FAULT:
  - Entered from any state when tank_low=1.
  - valve=0, pump=0, busy=0, fault=1.
  - Exit to GAP (fresh counter) on the first cycle with tank_low=0.
- Priority when events coincide in one cycle: tank_low, then enable=0, then timeout, then req drop.
- enable=0 in PRIME also aborts to GAP.
- req changes in PRIME do not abort priming. A dropped request is detected on entering WATER.
- Timeout does not block re-grant. Round-robin order means a still-dry timed-out zone is served again only after the other requesters.

## Timing
- Grant latency: req seen in IDLE at cycle n gives valve asserted at cycle n+1.
- Pump start: asserted on the cycle after the first tick following PRIME entry. The valve always leads the pump by ≥1 cycle.
- Shutdown: valve and pump drop together on the cycle after the exit condition.
- Pump on-time is never more than MAX_ON ticks plus one cycle.
- tick in the same cycle as a state entry is not counted by the new state.
- A tick in the entry cycle of GAP is ignored. GAP is exactly GAP ticks long after entry.
- Asynchronous reset mid-WATER clears valve and pump immediately, without waiting for a clock edge.

## Test plan
- Single zone (NZ=4, MAX_ON=5, GAP=2):
  - Stimulus: req=0100, hold.
  - Response: valve=0100 with pump=0 until the first tick; then pump=1 for exactly 5 ticks; then all 0 for 2 ticks.
  - Zone 2 is re-granted afterwards, because it is still requesting and is the only requester.
- Round-robin: req=1011 held, with each zone dropping its req 2 ticks into WATER. Grant order is 0, 1, 3, 0, with a GAP between each grant.
- Early drop: deassert req[1] mid-WATER. Next cycle: valve=0, pump=0, busy=0. zone_id stays 1.
- Tank fault:
  - Assert tank_low in WATER on zone 3. Next cycle: valve=0, pump=0, fault=1.
  - Release tank_low: fault=0 the next cycle, then 2 ticks of GAP, then re-grant resumes at zone 0.
- Simultaneous events: in one cycle, a tick with counter=4, req drop, and tank_low=1. Response is FAULT, not GAP.
- Reset and enable:
  - Asynchronous reset mid-WATER: outputs are 0 before the next clk edge, and zone 0 is served first afterwards.
  - enable=0 with req=1111: no grant ever occurs.
